nonce_uart_tx: RTL and testbench
================================

# nonce_uart_tx

Serial result transmitter for the hashcore golden-nonce output. It captures each `golden_nonce_out` word qualified by `golden_nonce_match` into a small FIFO. Each queued word is sent as a little-endian 4-byte frame on a UART 8N1 line. It is the outbound half of the serial comms path, replacing the JTAG GNON probe on boards without virtual wire.

## Interface
- `SPEED_MHZ`, 25: `hash_clk` frequency in MHz.
- `BAUD`, 115200: line rate. `BIT_CYCLES = SPEED_MHZ*1000000/BAUD`, integer truncation. It must be ≥ 2; the 25 MHz default gives 217.
- `FIFO_DEPTH`, 4: nonce queue entries. Power of 2, ≥ 2.
- `hash_clk` in 1: the block's single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `golden_nonce_in` in 32: nonce word from hashcore `golden_nonce_out`.
- `golden_nonce_match` in 1: one-cycle strobe; `golden_nonce_in` is valid on this cycle.
- `txd` out 1: UART serial output. Idle level is 1.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `overflow` out 1: sticky flag, set when a nonce is dropped. Only reset clears it.

## Operation
- **Reset values:** `txd`=1, `busy`=0, `overflow`=0. The FIFO is emptied and the FSM goes to IDLE. Reset asserted mid-frame aborts the frame and forces `txd` high immediately, asynchronously.
- **Push:** on each edge with `golden_nonce_match`=1, `golden_nonce_in` is written to the FIFO tail.
  - There is no de-duplication. Repeated values are sent repeatedly.
- **Full FIFO:** a push is dropped and `overflow` set, unless a pop happens on the same edge. A same-edge pop frees the slot, so that push is accepted.
- **FSM states:** IDLE → START → DATA → STOP → (START | CKSUM | IDLE).
  - **IDLE:** when the FIFO is non-empty, pop the head into a 32-bit shift register, clear the byte counter, and go to START.
  - **START:** `txd`=0 for `BIT_CYCLES` cycles.
  - **DATA:** 8 bits, LSB first, each held for `BIT_CYCLES` cycles.
  - **STOP:** `txd`=1 for `BIT_CYCLES` cycles. Then:
    - if bytes 0–2 are done, go to START for the next byte;
    - if byte 3 is done, go to IDLE (or to CKSUM when enabled, see Configuration).
- **Byte order:** `nonce[7:0]`, then `[15:8]`, `[23:16]`, `[31:24]`.
- **Counters:**
  - The baud counter runs 0..`BIT_CYCLES`-1 and wraps to 0 at each bit boundary.
  - The bit counter is 3 bits; the byte counter is 3 bits.
- **Back-to-back frames:** IDLE is transit-only when the FIFO is non-empty. The next start bit begins on the cycle after the stop bit ends, with no idle gap.
- **`busy`:** registered; equals (state≠IDLE) OR (FIFO count≠0).

## Timing
- The match strobe is sampled on edge k, and the FIFO count updates at k.
- When the block is idle and the FIFO is empty, IDLE pops at edge k+1. `txd` (registered) goes low after edge k+2.
- One frame occupies 40·`BIT_CYCLES` cycles, or 50·`BIT_CYCLES` with `NONCE_TX_CHECKSUM_EN`.
- `busy` rises after edge k+1. It falls after the edge that ends the last stop bit, provided the FIFO is empty.
- FIFO throughput is one push per cycle. One pop occurs per frame.

## Configuration
- `NONCE_TX_CHECKSUM_EN` defined: after byte 3's stop bit, the FSM sends a fifth byte (start/8 data/stop). Its value is `nonce[7:0]^nonce[15:8]^nonce[23:16]^nonce[31:24]`.
- Undefined: 4-byte frames only. No checksum logic is compiled in.

## Test plan
- **Reset:** hold `reset_n`=0 for 5 cycles → `txd`=1, `busy`=0, `overflow`=0. Release with no strobe for 100 cycles → outputs unchanged.
- **Single nonce:** `SPEED_MHZ`=1, `BAUD`=250000 (`BIT_CYCLES`=4); one strobe with 0x0000318F at edge 0.
  - `txd` low after edge 2.
  - Decoded bytes are 8F 31 00 00.
  - `busy` low after edge 162 (checksum off).
- **Burst overflow:** same parameters, `FIFO_DEPTH`=4; six strobes on consecutive edges with values 1..6.
  - Frames 1..5 are sent in order with no inter-frame gap.
  - Value 6 is dropped and `overflow`=1 after the sixth edge.
- **Checksum:** build with `NONCE_TX_CHECKSUM_EN`; send nonce 0x12345678 → bytes 78 56 34 12 08, frame of 200 cycles.
- **Reset mid-frame:** assert `reset_n` during the DATA state of byte 1 with 2 entries queued.
  - `txd`=1 immediately.
  - After release: `busy`=0 and no further frames are sent.
- **Simultaneous push/pop at full:** with the FIFO full, strobe on the same edge IDLE pops → the push is accepted and `overflow` stays 0.

Source files
------------

// File: rtl/nonce_uart_tx.sv
// nonce_uart_tx: captures golden-nonce words into a small FIFO and sends each one as a
// little-endian 4-byte UART 8N1 frame on txd. Consecutive frames go out with no idle gap.
// Build option: define NONCE_TX_CHECKSUM_EN to append a fifth byte to every frame, the XOR
// of the four nonce bytes.
module nonce_uart_tx #(
  parameter int unsigned SPEED_MHZ  = 25,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        hash_clk,
  input  logic        reset_n,
  input  logic [31:0] golden_nonce_in,
  input  logic        golden_nonce_match,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned BIT_CYCLES = SPEED_MHZ * 1000000 / BAUD;
  localparam int unsigned BaudW      = $clog2(BIT_CYCLES);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;

`ifdef NONCE_TX_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StCksum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e state_q, state_d;

  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [31:0]      shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q;
  logic             overflow_q;
  logic             bit_end;

  // Nonce FIFO
  logic [31:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [31:0]     fifo_head;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign push       = golden_nonce_match && (!fifo_full || pop);
  assign bit_end    = (baud_q == BaudW'(BIT_CYCLES - 1));

`ifdef NONCE_TX_CHECKSUM_EN
  logic [7:0] cksum_q;

  // Checksum of the word being sent, latched on the pop so the shift register can consume it
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      cksum_q <= '0;
    end else if (pop) begin
      cksum_q <= fifo_head[7:0] ^ fifo_head[15:8] ^ fifo_head[23:16] ^ fifo_head[31:24];
    end
  end
`endif

  // FIFO storage write (data only, no reset needed)
  always_ff @(posedge hash_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= golden_nonce_in;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if (golden_nonce_match && !push) overflow_q <= 1'b1;
    end
  end

  // Transmit FSM next-state, counters, FIFO pop and line level
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BaudW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) pop = 1'b1;
      end
      StStart: begin
        txd_d = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
`ifdef NONCE_TX_CHECKSUM_EN
      // Start bit of the checksum byte; shift_q already holds the checksum
      StCksum: begin
        txd_d = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
`endif
      StData: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          byte_d = byte_q + 3'd1;
          if (byte_q < 3'd3) begin
            state_d = StStart;
`ifdef NONCE_TX_CHECKSUM_EN
          end else if (byte_q == 3'd3) begin
            state_d = StCksum;
            shift_d = {24'h0, cksum_q};
`endif
          end else if (!fifo_empty) begin
            // Go straight to the next start bit: no idle gap between queued frames
            pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      shift_d = fifo_head;
      byte_d  = '0;
      state_d = StStart;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= (state_q != StIdle) || !fifo_empty;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nonce_uart_tx.sv
// tb_nonce_uart_tx: randomized and directed stimulus for nonce_uart_tx. A frame-level model
// (queue of pending nonces, frame schedule) predicts accepted nonces, frame start edges,
// busy and overflow; a UART decoder on txd pops and compares against the predictions.
module tb_nonce_uart_tx;

  localparam int SPEED_MHZ  = 1;
  localparam int BAUD       = 250000;
  localparam int FIFO_DEPTH = 4;
  localparam int B          = SPEED_MHZ * 1000000 / BAUD;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME = NB * 10 * B;

  logic        hash_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] golden_nonce_in = '0;
  logic        golden_nonce_match = 1'b0;
  logic        txd, busy, overflow;

  int tests = 0;
  int fails = 0;

  always #5 hash_clk = ~hash_clk;

  nonce_uart_tx #(
    .SPEED_MHZ (SPEED_MHZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .hash_clk          (hash_clk),
    .reset_n           (reset_n),
    .golden_nonce_in   (golden_nonce_in),
    .golden_nonce_match(golden_nonce_match),
    .txd               (txd),
    .busy              (busy),
    .overflow          (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: edge numbers count posedges since reset release (first edge = 1)
  int          m_edge    = 0;
  int          free_edge = 0;
  int          last_pop  = -1000000;
  logic [31:0] pend[$];
  logic [31:0] exp_nonce_q[$];
  int          exp_start_q[$];
  bit          busy_exp  = 1'b0;
  bit          ovf_exp   = 1'b0;

  initial forever begin
    @(posedge hash_clk or negedge reset_n);
    if (!reset_n) begin
      m_edge    = 0;
      free_edge = 0;
      last_pop  = -1000000;
      pend.delete();
      exp_nonce_q.delete();
      exp_start_q.delete();
      busy_exp  = 1'b0;
      ovf_exp   = 1'b0;
    end else begin
      m_edge++;
      // busy is registered: it reflects activity as it stood after the previous edge
      busy_exp = ((m_edge - 1 >= last_pop) && (m_edge - 1 < last_pop + FRAME))
                 || (pend.size() > 0);
      if (pend.size() > 0 && m_edge >= free_edge) begin
        pend.delete(0);
        last_pop  = m_edge;
        free_edge = m_edge + FRAME;
        exp_start_q.push_back(m_edge + 1);
      end
      if (golden_nonce_match) begin
        if (pend.size() < FIFO_DEPTH) begin
          pend.push_back(golden_nonce_in);
          exp_nonce_q.push_back(golden_nonce_in);
        end else begin
          ovf_exp = 1'b1;
        end
      end
    end
  end

  // Monitor: UART 8N1 decoder plus per-cycle busy/overflow comparison
  int                mon_phase = 0;
  int                mon_tmr   = 0;
  int                mon_bit   = 0;
  int                mon_byte  = 0;
  int                mon_byte_start = 0;
  logic [7:0]        mon_sh    = '0;
  logic [8*NB-1:0]   mon_word  = '0;

  initial forever begin
    @(negedge hash_clk);
    if (!reset_n) begin
      mon_phase = 0;
      mon_byte  = 0;
    end else begin
      check("busy", 64'(busy), 64'(busy_exp));
      check("overflow", 64'(overflow), 64'(ovf_exp));
      if (mon_phase == 0) begin
        if (txd == 1'b0) begin
          if (mon_byte == 0) begin
            if (exp_start_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_frame: start bit after edge %0d, required none", m_edge);
            end else begin
              check("frame_start_edge", 64'(m_edge), 64'(exp_start_q[0]));
              exp_start_q.delete(0);
            end
          end else begin
            check("byte_start_edge", 64'(m_edge), 64'(mon_byte_start + 10 * B));
          end
          mon_byte_start = m_edge;
          mon_phase      = 1;
          mon_tmr        = B / 2;
          mon_bit        = 0;
        end
      end else begin
        mon_tmr--;
        if (mon_tmr == 0) begin
          mon_tmr = B;
          if (mon_bit == 0) begin
            check("start_bit", 64'(txd), 64'(0));
          end else if (mon_bit <= 8) begin
            mon_sh = {txd, mon_sh[7:1]};
          end else begin
            check("stop_bit", 64'(txd), 64'(1));
            mon_word[mon_byte*8 +: 8] = mon_sh;
            mon_byte++;
            mon_phase = 0;
            if (mon_byte == NB) begin
              mon_byte = 0;
              if (exp_nonce_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_data: got %0h, required no frame", mon_word);
              end else begin
                check("frame_data", 64'(mon_word[31:0]), 64'(exp_nonce_q[0]));
`ifdef NONCE_TX_CHECKSUM_EN
                check("frame_cksum", 64'(mon_word[39:32]),
                      64'(exp_nonce_q[0][7:0] ^ exp_nonce_q[0][15:8] ^
                          exp_nonce_q[0][23:16] ^ exp_nonce_q[0][31:24]));
`endif
                exp_nonce_q.delete(0);
              end
            end
          end
          mon_bit++;
        end
      end
    end
  end

  task automatic drive(input bit m, input logic [31:0] v);
    @(negedge hash_clk);
    golden_nonce_match = m;
    golden_nonce_in    = v;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20000; i++) begin
      @(negedge hash_clk);
      if (exp_nonce_q.size() == 0 && !busy_exp) break;
    end
    check({name, "_pending"}, 64'(exp_nonce_q.size()), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_txd"}, 64'(txd), 64'(1));
  endtask

  initial begin
    bit found;

    // Reset and quiet idle
    repeat (5) @(negedge hash_clk);
    check("reset_txd", 64'(txd), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    reset_n = 1'b1;
    repeat (100) @(negedge hash_clk);
    check("idle_txd", 64'(txd), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));

    // Single nonce
    drive(1'b1, 32'h0000_318F);
    drive(1'b0, '0);
    drain("single");

    // Checksum reference value (also a plain frame in the default build)
    drive(1'b1, 32'h1234_5678);
    drive(1'b0, '0);
    drain("cksum_word");

    // Burst of six into a four-deep FIFO: value 6 dropped
    for (int i = 1; i <= 6; i++) drive(1'b1, 32'(i));
    drive(1'b0, '0);
    check("burst_overflow", 64'(overflow), 64'(1));
    drain("burst");
    check("overflow_sticky", 64'(overflow), 64'(1));

    // Reset during the data bits of byte 1 with a second nonce queued
    drive(1'b1, 32'h0000_0000);
    drive(1'b1, 32'hA5A5_A5A5);
    drive(1'b0, '0);
    repeat (50) @(negedge hash_clk);
    check("midframe_txd_low", 64'(txd), 64'(0));
    #2 reset_n = 1'b0;
    #1;
    check("midframe_reset_txd", 64'(txd), 64'(1));
    check("midframe_reset_busy", 64'(busy), 64'(0));
    check("midframe_reset_overflow", 64'(overflow), 64'(0));
    repeat (3) @(negedge hash_clk);
    reset_n = 1'b1;
    repeat (400) @(negedge hash_clk);
    check("after_reset_busy", 64'(busy), 64'(0));

    // Fill the FIFO, then push on the exact edge that pops it
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom);
    drive(1'b0, '0);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_edge + 1 == free_edge) begin
        found = 1'b1;
        break;
      end
      @(negedge hash_clk);
    end
    check("pushpop_edge_found", 64'(found), 64'(1));
    golden_nonce_match = 1'b1;
    golden_nonce_in    = 32'hC0FF_EE01;
    drive(1'b0, '0);
    check("pushpop_overflow", 64'(overflow), 64'(0));
    drain("pushpop");

    // Random traffic, including bursts that overflow
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom);
    end
    drive(1'b0, '0);
    drain("random");
    check("random_start_queue", 64'(exp_start_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
